// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_ACCESS,
        WR_ACCESS
    } state_t;

    typedef enum logic {
        OWN_RD,
        OWN_WR
    } owner_t;

    // Wide enough for the longest legal access hold of 15 cycles.
    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_access_timer.sv
// Loadable down-counter that measures how long an SRAM access is held.
// tc is high while the count is zero, i.e. during the final access cycle.
module sram_access_timer
    import sram_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM access controller: round-robin between a read and a write
// requester, holding each access on the SRAM pins for ACCESS_CYCLES cycles.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_read_enable,
    output logic              sram_write_enable,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    // The timer is loaded with the index of the final access cycle and counts down to it.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    owner_t            last_grant;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              pick_rd;
    logic              pick_wr;
    logic              access_end;

    sram_access_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (pick_rd | pick_wr),
        .load_val (LOAD_VAL),
        .tc       (access_end)
    );

    // Arbitration: a tie goes to whichever requester was not served last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pick_rd = 1'b0;
        pick_wr = 1'b0;
        if (state == IDLE) begin
            if (rd_req && (!wr_req || last_grant == OWN_WR)) begin
                pick_rd = 1'b1;
            end else if (wr_req) begin
                pick_wr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (pick_rd) begin
                    state_next = RD_ACCESS;
                end else if (pick_wr) begin
                    state_next = WR_ACCESS;
                end
            end
            RD_ACCESS, WR_ACCESS: begin
                if (access_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the capture registers are reset too, so the pins show known values from the first cycle.
        if (rst) begin
            last_grant <= OWN_WR;
            cap_addr   <= '0;
            cap_data   <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            wr_done    <= 1'b0;
        end else begin
            rd_valid <= (state == RD_ACCESS) && access_end;
            wr_done  <= (state == WR_ACCESS) && access_end;
            if (pick_rd) begin
                cap_addr   <= rd_addr;
                last_grant <= OWN_RD;
            end else if (pick_wr) begin
                cap_addr   <= wr_addr;
                cap_data   <= wr_data;
                last_grant <= OWN_WR;
            end
            if (state == RD_ACCESS && access_end) begin
                rd_data <= sram_rdata;
            end
        end
    end

    always_comb begin
        rd_gnt            = pick_rd;
        wr_gnt            = pick_wr;
        busy              = (state != IDLE);
        sram_addr         = '0;
        sram_read_enable  = 1'b0;
        sram_write_enable = 1'b0;
        sram_wdata        = '0;
        unique case (state)
            RD_ACCESS: begin
                sram_addr        = cap_addr;
                sram_read_enable = 1'b1;
            end
            WR_ACCESS: begin
                sram_addr         = cap_addr;
                sram_write_enable = 1'b1;
                sram_wdata        = cap_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a cycle model checks the ACCESS_CYCLES=2
// instance every cycle; a second instance covers the ACCESS_CYCLES=1 build.
module tb_sram_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int AC     = 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } xact_t;

    typedef struct {
        logic is_wr;
        int   c;
    } gnt_rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              rd_req, rd_gnt, rd_valid, wr_req, wr_gnt, wr_done, busy;
    logic              sram_read_enable, sram_write_enable;
    logic [ADDR_W-1:0] rd_addr, wr_addr, sram_addr;
    logic [DATA_W-1:0] rd_data, wr_data, sram_wdata, sram_rdata;

    logic              rd_req_1, rd_gnt_1, rd_valid_1, wr_req_1, wr_gnt_1, wr_done_1, busy_1;
    logic              sram_read_enable_1, sram_write_enable_1;
    logic [ADDR_W-1:0] rd_addr_1, wr_addr_1, sram_addr_1;
    logic [DATA_W-1:0] rd_data_1, wr_data_1, sram_wdata_1, sram_rdata_1;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_done(wr_done),
        .sram_addr(sram_addr), .sram_read_enable(sram_read_enable), .sram_write_enable(sram_write_enable),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .rd_req(rd_req_1), .rd_addr(rd_addr_1), .rd_gnt(rd_gnt_1), .rd_data(rd_data_1), .rd_valid(rd_valid_1),
        .wr_req(wr_req_1), .wr_addr(wr_addr_1), .wr_data(wr_data_1), .wr_gnt(wr_gnt_1), .wr_done(wr_done_1),
        .sram_addr(sram_addr_1), .sram_read_enable(sram_read_enable_1), .sram_write_enable(sram_write_enable_1),
        .sram_wdata(sram_wdata_1), .sram_rdata(sram_rdata_1), .busy(busy_1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // SRAM model for the main instance: combinational read, write on the clock edge.
    logic [DATA_W-1:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'(i * 53 + 7);
        mem[5] = 8'hA5;
        forever begin
            @(posedge clk);
            if (sram_write_enable === 1'b1) mem[sram_addr[5:0]] = sram_wdata;
        end
    end
    assign sram_rdata   = sram_read_enable ? mem[sram_addr[5:0]] : '0;
    assign sram_rdata_1 = sram_read_enable_1 ? (sram_addr_1[DATA_W-1:0] ^ 8'h5A) : '0;

    // Scoreboard queues, filled by stimulus and drained by the monitors.
    xact_t             rd_q[$];
    xact_t             wr_q[$];
    gnt_rec_t          gnt_log[$];
    logic [DATA_W-1:0] rd_q_1[$];
    int                g1_q[$];
    bit                mon_en = 1'b0;

    // Cycle model of the main instance.
    bit                m_infl = 1'b0, m_kind = 1'b0, m_done = 1'b0, m_done_kind = 1'b0, m_last_wr = 1'b1;
    int                m_pos = 0;
    logic [ADDR_W-1:0] m_addr = '0, m_done_addr = '0;
    logic [DATA_W-1:0] m_data = '0, m_done_data = '0, m_rd_data = '0;
    bit                e_rg, e_wg;
    xact_t             x;

    always @(negedge clk) begin
        if (mon_en) begin
            e_rg = !m_infl && rd_req && (!wr_req || m_last_wr);
            e_wg = !m_infl && wr_req && !e_rg;
            check("rd_gnt", 32'(rd_gnt), 32'(e_rg));
            check("wr_gnt", 32'(wr_gnt), 32'(e_wg));
            check("sram_read_enable", 32'(sram_read_enable), 32'(m_infl && !m_kind));
            check("sram_write_enable", 32'(sram_write_enable), 32'(m_infl && m_kind));
            check("sram_addr", 32'(sram_addr), 32'(m_infl ? m_addr : '0));
            check("sram_wdata", 32'(sram_wdata), 32'((m_infl && m_kind) ? m_data : '0));
            check("busy", 32'(busy), 32'(m_infl));
            check("rd_valid", 32'(rd_valid), 32'(m_done && !m_done_kind));
            check("wr_done", 32'(wr_done), 32'(m_done && m_done_kind));
            check("rd_data", 32'(rd_data), 32'(m_rd_data));
            if (m_done && m_done_kind) check("wr_mem", 32'(mem[m_done_addr[5:0]]), 32'(m_done_data));

            if (rst) begin
                m_infl    = 1'b0;
                m_done    = 1'b0;
                m_last_wr = 1'b1;
                m_rd_data = '0;
            end else begin
                m_done      = m_infl && (m_pos == AC);
                m_done_kind = m_kind;
                m_done_addr = m_addr;
                m_done_data = m_data;
                if (m_done && !m_kind) m_rd_data = m_data;
                if (m_infl) begin
                    if (m_pos == AC) m_infl = 1'b0;
                    else m_pos++;
                end else if (e_rg || e_wg) begin
                    x = '{addr: '0, data: '0};
                    if (e_rg) begin
                        check("rd_q_nonempty", 32'(rd_q.size() != 0), 32'd1);
                        if (rd_q.size() != 0) x = rd_q.pop_front();
                    end else begin
                        check("wr_q_nonempty", 32'(wr_q.size() != 0), 32'd1);
                        if (wr_q.size() != 0) x = wr_q.pop_front();
                    end
                    m_infl    = 1'b1;
                    m_pos     = 1;
                    m_kind    = e_wg;
                    m_last_wr = e_wg;
                    m_addr    = x.addr;
                    m_data    = x.data;
                end
            end
        end
    end

    // Monitor for the single-cycle-access instance.
    int                strobes1 = 0;
    int                g1;
    logic [DATA_W-1:0] e1;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (rd_gnt_1) g1_q.push_back(cyc);
            if (sram_read_enable_1) strobes1++;
            if (rd_valid_1) begin
                check("a1_q_nonempty", 32'(rd_q_1.size() != 0 && g1_q.size() != 0), 32'd1);
                e1 = (rd_q_1.size() != 0) ? rd_q_1.pop_front() : '0;
                g1 = (g1_q.size() != 0) ? g1_q.pop_front() : 0;
                check("a1_rd_data", 32'(rd_data_1), 32'(e1));
                check("a1_latency", 32'(cyc - g1), 32'd2);
                check("a1_strobes", 32'(strobes1), 32'd1);
                check("a1_no_wen", 32'(sram_write_enable_1), 32'd0);
                strobes1 = 0;
            end
        end
    end

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit got;
        got = 1'b0;
        rd_q.push_back('{addr: a, data: d});
        rd_addr = a;
        rd_req  = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rd_gnt) begin
                got = 1'b1;
                gnt_log.push_back('{is_wr: 1'b0, c: cyc});
            end
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        check("rd_granted", 32'(got), 32'd1);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit got;
        got = 1'b0;
        wr_q.push_back('{addr: a, data: d});
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (wr_gnt) begin
                got = 1'b1;
                gnt_log.push_back('{is_wr: 1'b1, c: cyc});
            end
            @(posedge clk); #1;
        end
        wr_req = 1'b0;
        check("wr_granted", 32'(got), 32'd1);
    endtask

    task automatic do_read1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int gc);
        bit got;
        got = 1'b0;
        gc  = -1;
        rd_q_1.push_back(d);
        rd_addr_1 = a;
        rd_req_1  = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rd_gnt_1) begin
                got = 1'b1;
                gc  = cyc;
            end
            @(posedge clk); #1;
        end
        rd_req_1 = 1'b0;
        check("a1_rd_granted", 32'(got), 32'd1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] src [0:63];
    int                gc [0:3];

    initial begin
        rst = 1'b1;
        rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req_1 = 1'b0; rd_addr_1 = '0; wr_req_1 = 1'b0; wr_addr_1 = '0; wr_data_1 = '0;
        for (int i = 0; i < 64; i++) src[i] = DATA_W'(i * 53 + 7);
        src[5] = 8'hA5;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention straight out of reset: expect R,W,R,W, one grant every 3 cycles.
        fork
            begin
                do_read(10, src[10]);
                do_read(11, src[11]);
            end
            begin
                do_write(40, 8'h11);
                do_write(41, 8'h22);
            end
        join
        src[40] = 8'h11;
        src[41] = 8'h22;
        check("contention_grants", 32'(gnt_log.size()), 32'd4);
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("contention_order", 32'(gnt_log[i].is_wr), 32'(i % 2));
            for (int i = 1; i < 4; i++) check("contention_spacing", 32'(gnt_log[i].c - gnt_log[i-1].c), 32'd3);
        end
        settle(4);

        do_read(5, 8'hA5);
        settle(4);
        check("read5_data", 32'(rd_data), 32'h0000_00A5);

        do_write(3, 8'h3C);
        src[3] = 8'h3C;
        settle(4);
        do_read(3, 8'h3C);
        settle(4);
        check("read3_after_write", 32'(rd_data), 32'h0000_003C);

        // Shift the image down by one address through interleaved reads and writes.
        fork
            for (int k = 0; k < 21; k++) do_read(ADDR_W'(k + 1), src[k + 1]);
            for (int k = 0; k < 21; k++) do_write(ADDR_W'(k), src[k + 1]);
        join
        settle(5);
        for (int k = 0; k < 21; k++) check("shift_dump", 32'(mem[k]), 32'(src[k + 1]));
        check("shift_dump_tail", 32'(mem[21]), 32'(src[21]));

        // Reset one cycle into a read access: the read is dropped.
        do_read(7, src[7]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ren", 32'(sram_read_enable), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rd_data", 32'(rd_data), 32'd0);
        settle(5);

        // Single-cycle accesses: one read, then three back-to-back reads.
        do_read1(7, 8'h5D, gc[0]);
        settle(3);
        fork
            begin
                do_read1(8, 8'h52, gc[1]);
                do_read1(9, 8'h53, gc[2]);
                do_read1(10, 8'h50, gc[3]);
            end
        join
        check("a1_b2b_spacing_a", 32'(gc[2] - gc[1]), 32'd2);
        check("a1_b2b_spacing_b", 32'(gc[3] - gc[2]), 32'd2);
        settle(4);

        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("a1_q_drained", 32'(rd_q_1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Single-port SRAM access controller shared between the pixel-fetch (read) requester and the result-writeback (write) requester of the edge-detector pipeline. It drives the off-chip SRAM model's read_enable/write_enable/address/data pins, holds each access for a fixed number of cycles, and arbitrates round-robin between requesters. It sits between the pipeline stages and the SRAM pins, replacing direct testbench-style driving of the SRAM.

Parameters:
ADDR_W, 19, SRAM address width (shared by both requesters)
DATA_W, 8, pixel data width
ACCESS_CYCLES, 2, cycles the enables and address are held per access (legal range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset
rd_req  in  1  read request, held until rd_gnt
rd_addr  in  ADDR_W  read address, valid with rd_req
rd_gnt  out  1  read request accepted this cycle
rd_data  out  DATA_W  read result, valid when rd_valid
rd_valid  out  1  one-cycle pulse, rd_data valid
wr_req  in  1  write request, held until wr_gnt
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_gnt  out  1  write request accepted this cycle
wr_done  out  1  one-cycle pulse, write completed
sram_addr  out  ADDR_W  SRAM address
sram_read_enable  out  1  SRAM read strobe
sram_write_enable  out  1  SRAM write strobe
sram_wdata  out  DATA_W  SRAM write data (external tristate keyed on sram_write_enable)
sram_rdata  in  DATA_W  SRAM read data
busy  out  1  access in progress (state != IDLE)

Behaviour:
- Reset: one clk; synchronous and active-high (rst). On reset: state IDLE, all outputs 0, rd_data 0, last_grant = WRITE (so the first tie goes to read).
- FSM states: IDLE, RD_ACCESS, WR_ACCESS. The access counter counts 0..ACCESS_CYCLES-1.
- IDLE, grant logic (combinational, same cycle):
  - Only rd_req: rd_gnt=1.
  - Only wr_req: wr_gnt=1.
  - Both: grant the requester opposite to last_grant.
  - The granted addr/data are captured at the edge, last_grant is updated, and the FSM moves to the matching ACCESS state.
- gnt outputs are only ever high in IDLE. rd_gnt and wr_gnt are never high together.
- ACCESS states:
  - sram_addr is held at the captured address; sram_read_enable (RD) or sram_write_enable (WR) is 1.
  - sram_wdata equals the captured data in WR_ACCESS, else 0.
  - The enables are never both 1.
  - On the edge ending the final access cycle (counter == ACCESS_CYCLES-1), RD latches sram_rdata into rd_data. The FSM then returns to IDLE.
- Completion: rd_valid or wr_done is 1 for exactly the first IDLE cycle after the access. rd_data holds its value until the next read completes.
- Latency (grant at cycle T):
  - Strobes active T+1..T+ACCESS_CYCLES.
  - rd_valid/wr_done at T+ACCESS_CYCLES+1.
  - A new grant is possible in that same cycle, giving max throughput of one access per ACCESS_CYCLES+1 cycles.
- Requesters keep req high and fields stable until gnt. req still high the cycle after gnt is a new request.
- Outside ACCESS states: sram_addr is 0 and both enables are 0.
- Reset mid-access: the transaction is dropped. Enables go 0 on the next cycle, and no rd_valid/wr_done is issued.
- Continuous contention with both requesters held high alternates R,W,R,W… starting with R after reset.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef enum state_t {IDLE, RD_ACCESS, WR_ACCESS}
  - typedef enum owner_t {OWN_RD, OWN_WR}
  - the counter width localparam (4 bits)
- One sub-module, sram_access_timer: a loadable down-counter with a terminal-count output that sets the hold length. Everything else is in sram_arbiter.

Test Plan:
- Read only, ACCESS_CYCLES=2: SRAM preloaded with addr 5 = 8'hA5; rd_req, addr 5 at T → rd_gnt at T, sram_read_enable at T+1..T+2 with sram_addr=5, rd_valid at T+3 with rd_data=8'hA5.
- Write only: wr_req, addr 3, data 8'h3C → wr_gnt at T, sram_write_enable at T+1..T+2, sram_wdata=8'h3C, wr_done at T+3; a subsequent read of addr 3 returns 8'h3C.
- Simultaneous req right after reset, both held high for 4 grants → grant order R,W,R,W; grants spaced 3 cycles apart; enables never both high.
- Stream of 21 reads at addrs 1..21 interleaved with 21 writes at addrs 0..20 carrying the read data → the memory dump of the write region equals the source image shifted by one.
- rst asserted at T+1 of a read access → enables 0 at T+2, no rd_valid, state IDLE, busy 0, rd_data 0.
- ACCESS_CYCLES=1 build: read at addr 7 → strobe only at T+1, rd_valid at T+2; back-to-back reads granted every 2 cycles.
